vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
Generates 640x480 @ 60 Hz VGA raster timing from a 25 MHz pixel clock. It outputs hSync and vSync, an active-video flag, the current pixel coordinates, and a one-cycle frame-boundary strobe. It sits between the clock divider and the pixel/colour pipeline of the VGA controller. The screenEnd strobe is also used as the game-logic frame tick.

Parameters:
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines per frame
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk25  input  1  pixel clock, 25 MHz; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
screenEnd  output  1  high for exactly one clk25 cycle per frame, at start of vertical blanking
active  output  1  high while (x,y) is inside the visible WIDTH x HEIGHT region
hSync  output  1  horizontal sync, active-low
vSync  output  1  vertical sync, active-low
x  output  10  current column, equals hCount[9:0]
y  output  9  current row, equals vCount[8:0]

Behaviour:
- Derived totals: H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK = 525.
- Internal state: hCount (10 bits) and vCount (10 bits). These are the only registers.
- While reset = 0 (asynchronous): hCount = 0, vCount = 0.
- Resulting output values during reset: active = 1, x = 0, y = 0, hSync = 1, vSync = 1, screenEnd = 0.
- Each rising edge of clk25 with reset = 1:
  - if hCount == H_TOTAL-1: hCount <= 0, and vCount <= (vCount == V_TOTAL-1) ? 0 : vCount+1;
  - otherwise hCount <= hCount+1 and vCount is held.
- All outputs are combinational decodes of the registered counters, so there is zero latency relative to the counters.
- active = (hCount < WIDTH) && (vCount < HEIGHT).
- hSync = 0 when WIDTH+H_FRONT <= hCount < WIDTH+H_FRONT+H_SYNC (656..751); 1 otherwise.
- vSync = 0 when HEIGHT+V_FRONT <= vCount < HEIGHT+V_FRONT+V_SYNC (490..491); 1 otherwise.
- screenEnd = (hCount == 0) && (vCount == HEIGHT).
  - Exactly one cycle per frame.
  - Period is H_TOTAL*V_TOTAL = 420000 clk25 cycles.
  - It never occurs while active = 1.
- x and y are meaningful only when active = 1. In blanking they follow the counters: x may reach 799, and y is vCount truncated to 9 bits, so vCount 512..524 shows as y 0..12.
- Wrap-around: (799, 524) -> (0, 0) on the next clock, with no dead cycle.
- Reset asserted mid-frame: counters return to 0 immediately, without waiting for a clock. After release, counting restarts at (0,0) on the first rising edge. No spurious screenEnd occurs until vCount next reaches HEIGHT.
- No inputs other than clock and reset; there is no handshake.

Decomposition:
- Shared package holds the default timing constants (640/16/96/48, 480/10/2/33) and the derived H_TOTAL and V_TOTAL, so the controller and benches use the same numbers.
- One sub-module is natural: vga_axis_counter.
  - Parameters: total count and the sync start/end points.
  - Outputs: count, wrap pulse, sync_n and visible.
  - Instantiated twice: the horizontal instance is always enabled; the vertical instance is enabled by the horizontal wrap pulse.

Test Plan:
- Reset: hold reset = 0 for 5 cycles -> x = 0, y = 0, active = 1, hSync = 1, vSync = 1, screenEnd = 0. Assert reset asynchronously between clock edges -> counters clear without a clock edge.
- Line timing: release reset, run 800 cycles.
  - active = 1 for hCount 0..639.
  - hSync = 0 exactly for cycles 656..751 (96 cycles).
  - x returns to 0 and y increments to 1 at cycle 800.
- Frame timing: run 420000 cycles.
  - vSync = 0 only during lines 490..491 (1600 cycles total).
  - active is never 1 for vCount >= 480.
  - Count after wrap is (0,0).
- screenEnd: over 3 frames -> exactly 3 single-cycle pulses, 420000 cycles apart, first at cycle 480*800 = 384000 after reset release, with x = 0 and vCount = 480 at each pulse.
- Mid-frame reset: assert reset at (300, 200) -> outputs return to reset values immediately. Release -> the next screenEnd arrives 384000 cycles later.
- Parameter override: WIDTH = 320, HEIGHT = 240, porches unchanged -> H_TOTAL = 480, V_TOTAL = 285. hSync-low and screenEnd positions move accordingly: hSync low at 336..431, screenEnd at vCount 240.

Source files
------------

// File: rtl/vga_timing_generator_pkg.sv
// Shared 640x480 @ 60 Hz timing constants for the VGA controller and its benches.
package vga_timing_generator_pkg;

   localparam int unsigned COUNT_W     = 10;

   localparam int unsigned DEF_WIDTH   = 640;
   localparam int unsigned DEF_H_FRONT = 16;
   localparam int unsigned DEF_H_SYNC  = 96;
   localparam int unsigned DEF_H_BACK  = 48;

   localparam int unsigned DEF_HEIGHT  = 480;
   localparam int unsigned DEF_V_FRONT = 10;
   localparam int unsigned DEF_V_SYNC  = 2;
   localparam int unsigned DEF_V_BACK  = 33;

   // Full period of one axis: visible region plus front porch, sync and back porch.
   function automatic int unsigned axis_total(input int unsigned visible,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return visible + front + sync + back;
   endfunction

   localparam int unsigned DEF_H_TOTAL = axis_total(DEF_WIDTH, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int unsigned DEF_V_TOTAL = axis_total(DEF_HEIGHT, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo-TOTAL counter with visible and active-low sync decodes.
module vga_axis_counter
   import vga_timing_generator_pkg::*;
#(
   parameter int unsigned TOTAL      = DEF_H_TOTAL,
   parameter int unsigned VISIBLE    = DEF_WIDTH,
   parameter int unsigned SYNC_START = DEF_WIDTH + DEF_H_FRONT,
   parameter int unsigned SYNC_END   = DEF_WIDTH + DEF_H_FRONT + DEF_H_SYNC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   output logic [COUNT_W-1:0] count,
   output logic               wrap,
   output logic               sync_n,
   output logic               visible
);

   localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
   localparam logic [COUNT_W-1:0] VIS_END = COUNT_W'(VISIBLE);
   localparam logic [COUNT_W-1:0] SYNC_LO = COUNT_W'(SYNC_START);
   localparam logic [COUNT_W-1:0] SYNC_HI = COUNT_W'(SYNC_END);

   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;

   // Next count: advance when enabled, wrapping to zero after the last position.
   always_comb begin
      count_d = count_q;
      wrap    = 1'b0;
      if (en) begin
         if (count_q == LAST) begin
            count_d = '0;
            wrap    = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Zero-latency decodes of the registered count.
   always_comb begin
      count   = count_q;
      visible = (count_q < VIS_END);
      sync_n  = !((count_q >= SYNC_LO) && (count_q < SYNC_HI));
   end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: horizontal and vertical axis counters plus frame strobe.
module vga_timing_generator
   import vga_timing_generator_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned HEIGHT  = DEF_HEIGHT,
   parameter int unsigned H_FRONT = DEF_H_FRONT,
   parameter int unsigned H_SYNC  = DEF_H_SYNC,
   parameter int unsigned H_BACK  = DEF_H_BACK,
   parameter int unsigned V_FRONT = DEF_V_FRONT,
   parameter int unsigned V_SYNC  = DEF_V_SYNC,
   parameter int unsigned V_BACK  = DEF_V_BACK
) (
   input  logic       clk25,
   input  logic       reset,
   output logic       screenEnd,
   output logic       active,
   output logic       hSync,
   output logic       vSync,
   output logic [9:0] x,
   output logic [8:0] y
);

   localparam int unsigned H_TOTAL = axis_total(WIDTH, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = axis_total(HEIGHT, V_FRONT, V_SYNC, V_BACK);
   localparam logic [COUNT_W-1:0] V_END_LINE = COUNT_W'(HEIGHT);

   logic [COUNT_W-1:0] h_count;
   logic [COUNT_W-1:0] v_count;
   logic               h_wrap;
   logic               v_wrap_unused;
   logic               h_visible;
   logic               v_visible;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .VISIBLE    (WIDTH),
      .SYNC_START (WIDTH + H_FRONT),
      .SYNC_END   (WIDTH + H_FRONT + H_SYNC)
   ) u_h_axis (
      .clk     (clk25),
      .rst_n   (reset),
      .en      (1'b1),
      .count   (h_count),
      .wrap    (h_wrap),
      .sync_n  (hSync),
      .visible (h_visible)
   );

   // Vertical axis steps once per line, on the horizontal wrap.
   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .VISIBLE    (HEIGHT),
      .SYNC_START (HEIGHT + V_FRONT),
      .SYNC_END   (HEIGHT + V_FRONT + V_SYNC)
   ) u_v_axis (
      .clk     (clk25),
      .rst_n   (reset),
      .en      (h_wrap),
      .count   (v_count),
      .wrap    (v_wrap_unused),
      .sync_n  (vSync),
      .visible (v_visible)
   );

   // Pixel position, visibility and the one-cycle frame strobe at the first blank line.
   always_comb begin
      active    = h_visible && v_visible;
      x         = h_count;
      y         = v_count[8:0];
      screenEnd = (h_count == '0) && (v_count == V_END_LINE);
   end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three parameterisations against a cycle-count reference model.
module tb_vga_timing_generator;

   logic clk25 = 1'b0;
   logic reset = 1'b0;

   always #20 clk25 = ~clk25;

   // Instance A: default 640x480 timing.
   logic       se_a, act_a, hs_a, vs_a;
   logic [9:0] x_a;
   logic [8:0] y_a;
   // Instance B: 320x240 with default porches.
   logic       se_b, act_b, hs_b, vs_b;
   logic [9:0] x_b;
   logic [8:0] y_b;
   // Instance C: tiny raster so whole frames fit in a short run.
   logic       se_c, act_c, hs_c, vs_c;
   logic [9:0] x_c;
   logic [8:0] y_c;

   vga_timing_generator dut_a (
      .clk25(clk25), .reset(reset), .screenEnd(se_a), .active(act_a),
      .hSync(hs_a), .vSync(vs_a), .x(x_a), .y(y_a)
   );

   vga_timing_generator #(.WIDTH(320), .HEIGHT(240)) dut_b (
      .clk25(clk25), .reset(reset), .screenEnd(se_b), .active(act_b),
      .hSync(hs_b), .vSync(vs_b), .x(x_b), .y(y_b)
   );

   vga_timing_generator #(
      .WIDTH(16), .HEIGHT(12), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
   ) dut_c (
      .clk25(clk25), .reset(reset), .screenEnd(se_c), .active(act_c),
      .hSync(hs_c), .vSync(vs_c), .x(x_c), .y(y_c)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: position is the cycle count since reset release folded onto the raster.
   function automatic logic [22:0] ref_out(input int unsigned t,
                                           input int unsigned w, input int unsigned hgt,
                                           input int unsigned hf, input int unsigned hsw, input int unsigned hb,
                                           input int unsigned vf, input int unsigned vsw, input int unsigned vb);
      int unsigned ht, vt, h, v;
      logic se, act, hs, vs;
      logic [9:0] xv;
      logic [8:0] yv;
      ht  = w + hf + hsw + hb;
      vt  = hgt + vf + vsw + vb;
      h   = t % ht;
      v   = (t / ht) % vt;
      act = (h < w) && (v < hgt);
      hs  = !((h >= w + hf) && (h < w + hf + hsw));
      vs  = !((v >= hgt + vf) && (v < hgt + vf + vsw));
      se  = (h == 0) && (v == hgt);
      xv  = h[9:0];
      yv  = v[8:0];
      return {se, act, hs, vs, xv, yv};
   endfunction

   function automatic logic [22:0] ref_a(input int unsigned t);
      return ref_out(t, 640, 480, 16, 96, 48, 10, 2, 33);
   endfunction
   function automatic logic [22:0] ref_b(input int unsigned t);
      return ref_out(t, 320, 240, 16, 96, 48, 10, 2, 33);
   endfunction
   function automatic logic [22:0] ref_c(input int unsigned t);
      return ref_out(t, 16, 12, 2, 3, 2, 1, 2, 2);
   endfunction

   localparam int unsigned C_FRAME = 23 * 17;
   localparam int unsigned C_FIRST = 12 * 23;

   // Cycles elapsed since reset was last released.
   int unsigned t = 0;
   always @(posedge clk25 or negedge reset) begin
      if (!reset) t <= 0;
      else        t <= t + 1;
   end

   bit          mon_en   = 1'b0;
   bit          pulse_en = 1'b0;
   int unsigned pulses[$];

   task automatic check_all(input string phase);
      check_val({phase, " rasterA"}, 32'({se_a, act_a, hs_a, vs_a, x_a, y_a}), 32'(ref_a(t)));
      check_val({phase, " rasterB"}, 32'({se_b, act_b, hs_b, vs_b, x_b, y_b}), 32'(ref_b(t)));
      check_val({phase, " rasterC"}, 32'({se_c, act_c, hs_c, vs_c, x_c, y_c}), 32'(ref_c(t)));
   endtask

   always @(negedge clk25) begin
      if (mon_en) begin
         check_all("cycle");
         if (pulse_en && se_c) pulses.push_back(t);
      end
   end

   task automatic run(input int unsigned n);
      repeat (n) @(posedge clk25);
   endtask

   task automatic async_reset_pulse(input int unsigned hold);
      @(posedge clk25);
      #7 reset = 1'b0;
      #1 check_all("async_rst");
      check_val("async_rst_xA", 32'(x_a), 32'd0);
      check_val("async_rst_yA", 32'(y_a), 32'd0);
      repeat (hold) @(posedge clk25);
      @(negedge clk25);
      #5 reset = 1'b1;
   endtask

   initial begin
      int unsigned span;
      reset = 1'b0;
      mon_en = 1'b1;
      run(5);
      @(negedge clk25);
      #1 check_val("reset_vals", 32'({se_a, act_a, hs_a, vs_a, x_a, y_a}), 32'({1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 9'd0}));
      #4 reset = 1'b1;

      // Several lines of every instance, plus full frames of the tiny one.
      pulse_en = 1'b1;
      run(3 * C_FRAME);
      @(negedge clk25);
      #1 pulse_en = 1'b0;
      check_val("pulse_count", 32'(pulses.size()), 32'd3);
      if (pulses.size() == 3) begin
         check_val("pulse_first", pulses[0], C_FIRST);
         check_val("pulse_gap1", pulses[1] - pulses[0], C_FRAME);
         check_val("pulse_gap2", pulses[2] - pulses[1], C_FRAME);
      end
      run(2500 - 3 * C_FRAME);

      // Mid-frame reset at random points with random hold times.
      for (int i = 0; i < 20; i++) begin
         span = $urandom_range(3000, 1);
         run(span);
         async_reset_pulse($urandom_range(4, 1));
      end

      // After a mid-frame reset the tiny raster's next strobe must be one full blank-start away.
      run(200);
      async_reset_pulse(2);
      pulses.delete();
      pulse_en = 1'b1;
      run(C_FIRST + 5);
      @(negedge clk25);
      #1 pulse_en = 1'b0;
      check_val("restart_pulses", 32'(pulses.size()), 32'd1);
      if (pulses.size() == 1) check_val("restart_first", pulses[0], C_FIRST);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
